// File: rtl/msg_framer_pkg.sv
// Shared types for the message framer: the input FSM state and the FIFO
// entry layout. The header length check also lives here so that the FSM
// and any future consumer classify lengths the same way.
package msg_framer_pkg;

    // The FIFO entry layout fixes the payload width. Keep the framer's
    // DATA_W parameter equal to this value.
    localparam int unsigned ENTRY_DATA_W = 8;

    typedef enum logic [1:0] {
        S_HDR,
        S_BODY,
        S_DROP
    } state_t;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic                    head;
        logic                    tail;
    } entry_t;

    // A header is usable when the message fits the FIFO and has a distinct
    // head word and tail word.
    function automatic logic len_legal(input logic [ENTRY_DATA_W-1:0] len,
                                       input int unsigned depth);
        return (32'(len) >= 32'd2) && (32'(len) <= depth);
    endfunction

    // Oversize messages still carry a body that has to be skipped.
    function automatic logic len_oversize(input logic [ENTRY_DATA_W-1:0] len,
                                          input int unsigned depth);
        return 32'(len) > depth;
    endfunction

endpackage

// File: rtl/msg_framer_if.sv
// Upstream word stream and downstream framed-word bundle of the framer.
// The master side feeds words and watches the framed output; the slave
// side is the framer itself.
interface msg_framer_if #(
    parameter int DATA_W = msg_framer_pkg::ENTRY_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              valid;
    logic              head;
    logic              tail;
    logic [DATA_W-1:0] data;
    logic              err_len;

    modport master (
        output in_valid, in_data,
        input  in_ready, valid, head, tail, data, err_len
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, valid, head, tail, data, err_len
    );
endinterface

// File: rtl/msg_fifo.sv
// Synchronous first-word-fall-through FIFO holding framed entries. The
// read port shows the oldest entry combinationally so the framer can load
// its output registers on the same edge that pops it.
module msg_fifo
    import msg_framer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   wr_en,
    input  entry_t wr_data,
    input  logic   rd_en,
    output entry_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // A write into a full FIFO is fine when the same edge pops the slot.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array write port.
    // NOTE: the array has no reset; the pointers alone define which slots
    // hold valid entries, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance on write and read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/msg_framer.sv
// Length-prefixed stream to head/tail framed bursts. Incoming messages are
// stored whole in the FIFO; output starts only once a complete message is
// buffered, so every burst leaves gap-free with one head and one tail.
module msg_framer
    import msg_framer_pkg::*;
#(
    parameter int DATA_W = ENTRY_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic         clock,
    input  logic         reset,
    msg_framer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   len;
    logic [CNT_W-1:0]    msg_cnt;
    logic                out_busy;

    logic                ready;
    logic                in_body;
    logic                accept;
    logic                hdr_ok;
    logic                hdr_big;
    logic                last_word;
    logic                wr_en;
    logic                pop;
    logic                cnt_inc;
    logic                cnt_dec;
    logic                fifo_full;
    logic                fifo_empty;
    entry_t              wr_entry;
    entry_t              rd_entry;

    assign bus.in_ready = ready;
    assign accept       = bus.in_valid && ready;
    assign hdr_ok       = len_legal(bus.in_data, DEPTH);
    assign hdr_big      = len_oversize(bus.in_data, DEPTH);
    assign last_word    = (rem == DATA_W'(1));

    assign wr_en        = accept && in_body;
    assign wr_entry     = '{data: bus.in_data, head: (rem == len), tail: last_word};

    // Unload only a complete message, or continue one already started.
    assign pop          = (out_busy || msg_cnt != '0) && !fifo_empty;
    assign cnt_inc      = wr_en && wr_entry.tail;
    assign cnt_dec      = pop && rd_entry.tail;

    msg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Input FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Input FSM next-state: classify headers, count body/drop words down.
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for state_next.
    always_comb begin
        state_next = state;
        case (state)
            S_HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        state_next = S_BODY;
                    end else if (hdr_big) begin
                        state_next = S_DROP;
                    end
                end
            end
            S_BODY, S_DROP: begin
                if (accept && last_word) begin
                    state_next = S_HDR;
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    // Input FSM outputs: upstream ready and FIFO write select.
    always_comb begin
        ready   = 1'b0;
        in_body = 1'b0;
        case (state)
            S_HDR:   ready = 1'b1;
            S_BODY: begin
                ready   = !fifo_full;
                in_body = 1'b1;
            end
            S_DROP:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
        if (!reset) begin
            ready = 1'b0;
        end
    end

    // Length bookkeeping: latch L on a header, count down on each word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem <= '0;
            len <= '0;
        end else if (accept) begin
            if (state == S_HDR) begin
                rem <= bus.in_data;
                len <= bus.in_data;
            end else begin
                rem <= rem - DATA_W'(1);
            end
        end
    end

    // One-cycle error pulse for a rejected header.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.err_len <= 1'b0;
        end else begin
            bus.err_len <= accept && (state == S_HDR) && !hdr_ok;
        end
    end

    // Count of whole messages sitting in the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msg_cnt <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   msg_cnt <= msg_cnt + CNT_W'(1);
                2'b01:   msg_cnt <= msg_cnt - CNT_W'(1);
                default: msg_cnt <= msg_cnt;
            endcase
        end
    end

    // Burst-in-progress flag: set by a popped head, cleared by a popped tail.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_busy <= 1'b0;
        end else if (pop) begin
            if (rd_entry.tail) begin
                out_busy <= 1'b0;
            end else if (rd_entry.head) begin
                out_busy <= 1'b1;
            end
        end
    end

    // Registered downstream word; data holds its value between pops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.valid <= 1'b0;
            bus.head  <= 1'b0;
            bus.tail  <= 1'b0;
            bus.data  <= '0;
        end else begin
            bus.valid <= pop;
            bus.head  <= pop && rd_entry.head;
            bus.tail  <= pop && rd_entry.tail;
            if (pop) begin
                bus.data <= rd_entry.data;
            end
        end
    end

endmodule

// File: tb/tb_msg_framer.sv
// Directed bench for msg_framer: each scenario task drives a word stream
// and compares the collected output words against hand-computed values.
module tb_msg_framer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    typedef struct {
        logic          head;
        logic          tail;
        logic [DW-1:0] data;
        int            cyc;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   err_cnt = 0;
    obs_t q[$];

    msg_framer_if #(.DATA_W(DW)) bus ();

    msg_framer #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Collect every presented output word and every error pulse.
    always @(negedge clock) begin
        if (bus.valid === 1'b1) begin
            q.push_back('{head: bus.head, tail: bus.tail, data: bus.data, cyc: cyc});
        end
        if (bus.err_len === 1'b1) begin
            err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Present one word and hold it until accepted; returns at the falling
    // edge just after the accepting rising edge. in_valid is left high.
    task automatic send_word(input logic [DW-1:0] d);
        int budget = 64;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && budget > 0) begin
            stall_cnt++;
            budget--;
            @(negedge clock);
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL send_word timeout got in_ready=%b want 1", bus.in_ready);
        end
        @(negedge clock);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(negedge clock);
    endtask

    // Wait (bounded) for n collected output words, then let the pipe settle.
    task automatic drain(input int n, input int budget);
        int k = 0;
        bus.in_valid = 1'b0;
        while (q.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        repeat (4) @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.valid, bus.head, bus.tail, bus.err_len, bus.in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.valid, bus.head, bus.tail, bus.err_len, bus.in_ready});
        end
        checks++;
        if (bus.data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h want 00", bus.data);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL release_idle got %0d words want 0", q.size());
        end
    endtask

    task automatic test_single();
        logic [9:0] exp_e [3];
        int n;
        exp_e = '{{1'b1, 1'b0, 8'hA1}, {1'b0, 1'b0, 8'hA2}, {1'b0, 1'b1, 8'hA3}};
        q.delete();
        send_word(8'd3);
        send_word(8'hA1);
        send_word(8'hA2);
        send_word(8'hA3);
        n = cyc;
        drain(3, 20);
        checks++;
        if (q.size() != 3) begin
            errors++;
            $display("FAIL single_count got %0d want 3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) begin
                checks++;
                if ({q[i].head, q[i].tail, q[i].data} !== exp_e[i]) begin
                    errors++;
                    $display("FAIL single_word%0d got %h want %h", i,
                             {q[i].head, q[i].tail, q[i].data}, exp_e[i]);
                end
                checks++;
                if (q[i].cyc != n + 1 + i) begin
                    errors++;
                    $display("FAIL single_cycle%0d got %0d want %0d", i, q[i].cyc, n + 1 + i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_e [5];
        int n;
        int s0;
        exp_e = '{{1'b1, 1'b0, 8'hB1}, {1'b0, 1'b0, 8'hB2}, {1'b0, 1'b1, 8'hB3},
                  {1'b1, 1'b0, 8'hC1}, {1'b0, 1'b1, 8'hC2}};
        q.delete();
        s0 = stall_cnt;
        send_word(8'd3);
        send_word(8'hB1);
        send_word(8'hB2);
        send_word(8'hB3);
        n = cyc;
        send_word(8'd2);
        send_word(8'hC1);
        send_word(8'hC2);
        drain(5, 30);
        checks++;
        if (stall_cnt != s0) begin
            errors++;
            $display("FAIL b2b_stalls got %0d want 0", stall_cnt - s0);
        end
        checks++;
        if (q.size() != 5) begin
            errors++;
            $display("FAIL b2b_count got %0d want 5", q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < q.size()) begin
                checks++;
                if ({q[i].head, q[i].tail, q[i].data} !== exp_e[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d got %h want %h", i,
                             {q[i].head, q[i].tail, q[i].data}, exp_e[i]);
                end
                checks++;
                if (q[i].cyc != n + 1 + i) begin
                    errors++;
                    $display("FAIL b2b_cycle%0d got %0d want %0d", i, q[i].cyc, n + 1 + i);
                end
            end
        end
    endtask

    task automatic test_bad_len();
        logic [9:0] exp_e [2];
        int e0;
        exp_e = '{{1'b1, 1'b0, 8'hD1}, {1'b0, 1'b1, 8'hD2}};
        q.delete();
        e0 = err_cnt;
        send_word(8'd1);
        checks++;
        if (bus.err_len !== 1'b1) begin
            errors++;
            $display("FAIL err_len1_pulse got %b want 1", bus.err_len);
        end
        idle();
        checks++;
        if (bus.err_len !== 1'b0) begin
            errors++;
            $display("FAIL err_len1_clear got %b want 0", bus.err_len);
        end
        send_word(8'd0);
        checks++;
        if (bus.err_len !== 1'b1) begin
            errors++;
            $display("FAIL err_len0_pulse got %b want 1", bus.err_len);
        end
        idle();
        send_word(8'(DEPTH + 1));
        checks++;
        if (bus.err_len !== 1'b1) begin
            errors++;
            $display("FAIL err_big_pulse got %b want 1", bus.err_len);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL drop_ready%0d got %b want 1", i, bus.in_ready);
            end
            // Payload that would be a legal header if the drop ended early.
            send_word(8'd2);
        end
        idle();
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bad_len_output got %0d words want 0", q.size());
        end
        checks++;
        if (err_cnt - e0 != 3) begin
            errors++;
            $display("FAIL err_len_count got %0d want 3", err_cnt - e0);
        end
        send_word(8'd2);
        send_word(8'hD1);
        send_word(8'hD2);
        drain(2, 20);
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL after_bad_count got %0d want 2", q.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (i < q.size()) begin
                checks++;
                if ({q[i].head, q[i].tail, q[i].data} !== exp_e[i]) begin
                    errors++;
                    $display("FAIL after_bad_word%0d got %h want %h", i,
                             {q[i].head, q[i].tail, q[i].data}, exp_e[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [9:0] exp_w;
        int n;
        int s0;
        q.delete();
        s0 = stall_cnt;
        send_word(8'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            send_word(8'(8'h10 + i));
        end
        n = cyc;
        send_word(8'd2);
        send_word(8'hF1);
        send_word(8'hF2);
        drain(DEPTH + 2, 60);
        checks++;
        if (stall_cnt != s0) begin
            errors++;
            $display("FAIL full_stalls got %0d want 0", stall_cnt - s0);
        end
        checks++;
        if (q.size() != DEPTH + 2) begin
            errors++;
            $display("FAIL full_count got %0d want %0d", q.size(), DEPTH + 2);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) begin
                exp_w = {(i == 0), (i == DEPTH - 1), 8'(8'h10 + i)};
            end else if (i == DEPTH) begin
                exp_w = {1'b1, 1'b0, 8'hF1};
            end else begin
                exp_w = {1'b0, 1'b1, 8'hF2};
            end
            if (i < q.size()) begin
                checks++;
                if ({q[i].head, q[i].tail, q[i].data} !== exp_w) begin
                    errors++;
                    $display("FAIL full_word%0d got %h want %h", i,
                             {q[i].head, q[i].tail, q[i].data}, exp_w);
                end
                checks++;
                if (q[i].cyc != n + 1 + i) begin
                    errors++;
                    $display("FAIL full_cycle%0d got %0d want %0d", i, q[i].cyc, n + 1 + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp_e [2];
        int n;
        exp_e = '{{1'b1, 1'b0, 8'h71}, {1'b0, 1'b1, 8'h72}};
        q.delete();
        send_word(8'd4);
        send_word(8'h61);
        send_word(8'h62);
        send_word(8'h63);
        send_word(8'h64);
        bus.in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if ({bus.valid, bus.head, bus.tail, bus.data} !== {3'b100, 8'h62}) begin
            errors++;
            $display("FAIL mid_second_word got %h want %h",
                     {bus.valid, bus.head, bus.tail, bus.data}, {3'b100, 8'h62});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.valid, bus.head, bus.tail, bus.in_ready, bus.data} !== 12'h0) begin
            errors++;
            $display("FAIL mid_reset_clear got %h want 000",
                     {bus.valid, bus.head, bus.tail, bus.in_ready, bus.data});
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL mid_truncate got %0d words want 2", q.size());
        end
        q.delete();
        send_word(8'd2);
        send_word(8'h71);
        send_word(8'h72);
        n = cyc;
        drain(2, 20);
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL post_reset_count got %0d want 2", q.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (i < q.size()) begin
                checks++;
                if ({q[i].head, q[i].tail, q[i].data} !== exp_e[i]) begin
                    errors++;
                    $display("FAIL post_reset_word%0d got %h want %h", i,
                             {q[i].head, q[i].tail, q[i].data}, exp_e[i]);
                end
                checks++;
                if (q[i].cyc != n + 1 + i) begin
                    errors++;
                    $display("FAIL post_reset_cycle%0d got %0d want %0d", i, q[i].cyc, n + 1 + i);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [9:0] exp_e [4];
        int n;
        exp_e = '{{1'b1, 1'b0, 8'hE1}, {1'b0, 1'b0, 8'hE2},
                  {1'b0, 1'b0, 8'hE3}, {1'b0, 1'b1, 8'hE4}};
        q.delete();
        send_word(8'd4);
        idle();
        send_word(8'hE1);
        idle();
        send_word(8'hE2);
        idle();
        send_word(8'hE3);
        idle();
        send_word(8'hE4);
        n = cyc;
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL gaps_early got %0d words want 0", q.size());
        end
        drain(4, 20);
        checks++;
        if (q.size() != 4) begin
            errors++;
            $display("FAIL gaps_count got %0d want 4", q.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) begin
                checks++;
                if ({q[i].head, q[i].tail, q[i].data} !== exp_e[i]) begin
                    errors++;
                    $display("FAIL gaps_word%0d got %h want %h", i,
                             {q[i].head, q[i].tail, q[i].data}, exp_e[i]);
                end
                checks++;
                if (q[i].cyc != n + 1 + i) begin
                    errors++;
                    $display("FAIL gaps_cycle%0d got %0d want %0d", i, q[i].cyc, n + 1 + i);
                end
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_len();
        test_full();
        test_reset_mid();
        test_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
